// File: rtl/uproc_pkg.sv
// Shared types and constants for the uProcessor boot path: loader states, error codes,
// and the program-memory geometry also used by the program counter and program memory.
package uproc_pkg;

  localparam int PM_ADDR_W = 6;
  localparam int PM_INS_W  = 13;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LO,
    HI,
    CHK,
    DONE,
    ERR
  } loader_state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_HIBYTE  = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle watchdog for the loader: counts enabled cycles since the last clear and
// flags expiry when the count reaches TIMEOUT (TIMEOUT of 0 never expires).
module loader_timeout #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic nReset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] count;

  // Holds at TIMEOUT once reached so the expiry flag stays stable until cleared.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (TIMEOUT != 0) && (count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/prog_loader.sv
// Boot loader: assembles a checksummed byte image into instructions, writes them to
// program memory and releases the core from reset only after a complete, valid image.
module prog_loader
  import uproc_pkg::*;
#(
  parameter int ADDR_W  = PM_ADDR_W,
  parameter int INS_W   = PM_INS_W,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              start_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              pm_we_o,
  output logic [ADDR_W-1:0] pm_addr_o,
  output logic [INS_W-1:0]  pm_data_o,
  output logic              core_nreset_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        err_o
);

  loader_state_t     state;
  logic [ADDR_W-1:0] n_m1;
  logic [ADDR_W:0]   word_cnt;
  logic [7:0]        sum;
  logic [7:0]        lo_byte;
  logic              busy;
  logic              xfer;
  logic              expired;

  // Only INS_W-8 bits of the high byte belong to the instruction; the rest must be zero.
  function automatic logic hi_byte_bad(input logic [7:0] b);
    return (b >> (INS_W - 8)) != 8'd0;
  endfunction

  assign busy         = (state == HDR) || (state == LO) || (state == HI) || (state == CHK);
  assign xfer         = byte_valid_i && busy;
  assign byte_ready_o = busy;
  assign busy_o       = busy;
  assign done_o       = (state == DONE);

  loader_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .nReset (nReset),
    .clear  (xfer || (start_i && !busy)),
    .enable (busy),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state         <= IDLE;
      err_o         <= ERR_NONE;
      core_nreset_o <= 1'b0;
      pm_we_o       <= 1'b0;
      pm_addr_o     <= '0;
      pm_data_o     <= '0;
      n_m1          <= '0;
      word_cnt      <= '0;
      sum           <= '0;
      lo_byte       <= '0;
    end else begin
      pm_we_o       <= 1'b0;
      // Dropped in the same edge that accepts start_i, so no write can see the core running.
      core_nreset_o <= (state == DONE) && !start_i;
      if (busy && !xfer && expired) begin
        state <= ERR;
        err_o <= ERR_TIMEOUT;
      end else begin
        case (state)
          IDLE, DONE, ERR: begin
            if (start_i) begin
              state <= HDR;
              err_o <= ERR_NONE;
            end
          end
          HDR: begin
            if (xfer) begin
              n_m1     <= byte_i[ADDR_W-1:0];
              sum      <= byte_i;
              word_cnt <= '0;
              state    <= LO;
            end
          end
          LO: begin
            if (xfer) begin
              lo_byte <= byte_i;
              sum     <= sum + byte_i;
              state   <= HI;
            end
          end
          HI: begin
            if (xfer) begin
              if (hi_byte_bad(byte_i)) begin
                state <= ERR;
                err_o <= ERR_HIBYTE;
              end else begin
                pm_we_o   <= 1'b1;
                pm_addr_o <= word_cnt[ADDR_W-1:0];
                pm_data_o <= {byte_i[INS_W-9:0], lo_byte};
                sum       <= sum + byte_i;
                word_cnt  <= word_cnt + 1'b1;
                state     <= (word_cnt == {1'b0, n_m1}) ? CHK : LO;
              end
            end
          end
          CHK: begin
            if (xfer) begin
              if (byte_i == sum) begin
                state <= DONE;
              end else begin
                state <= ERR;
                err_o <= ERR_CSUM;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomised bench for prog_loader: byte images with gaps are scored against a
// byte-walk model of the image format, plus directed boundary cases.
module tb_prog_loader;

  localparam int ADDR_W  = 6;
  localparam int INS_W   = 13;
  localparam int TIMEOUT = 40;

  logic              clk = 1'b0;
  logic              nReset = 1'b0;
  logic              start_i = 1'b0;
  logic [7:0]        byte_i = 8'd0;
  logic              byte_valid_i = 1'b0;
  logic              byte_ready_o;
  logic              pm_we_o;
  logic [ADDR_W-1:0] pm_addr_o;
  logic [INS_W-1:0]  pm_data_o;
  logic              core_nreset_o;
  logic              busy_o;
  logic              done_o;
  logic [1:0]        err_o;

  prog_loader #(.ADDR_W(ADDR_W), .INS_W(INS_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .nReset       (nReset),
    .start_i      (start_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .pm_we_o      (pm_we_o),
    .pm_addr_o    (pm_addr_o),
    .pm_data_o    (pm_data_o),
    .core_nreset_o(core_nreset_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] img_q[$];
  int         gap_q[$];
  int         exp_q[$];
  int         act_q[$];
  int         exp_err, exp_done, exp_acc;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Every write seen on the memory port, encoded as addr * 2^INS_W + data.
  always @(negedge clk) begin
    if (pm_we_o) begin
      act_q.push_back(int'(pm_addr_o) * (1 << INS_W) + int'(pm_data_o));
      check("core_held_on_write", int'(core_nreset_o), 0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    byte_valid_i = 1'b0;
    repeat (gap) tick();
    byte_i       = b;
    byte_valid_i = 1'b1;
    ok           = byte_ready_o;
    tick();
    byte_valid_i = 1'b0;
  endtask

  // Reference: walk the image byte by byte following the format rules.
  task automatic model();
    int n;
    logic [7:0] s, lo;
    exp_q.delete();
    exp_err = 0; exp_done = 0; exp_acc = 0; n = 0; s = 8'd0; lo = 8'd0;
    for (int k = 0; k < img_q.size(); k++) begin
      if (gap_q[k] > TIMEOUT) begin exp_err = 3; return; end
      exp_acc++;
      if (k == 0) begin
        n = int'(img_q[0]) % (1 << ADDR_W) + 1;
        s = img_q[0];
      end else if (k <= 2 * n) begin
        if (k % 2 == 1) lo = img_q[k];
        else begin
          if (int'(img_q[k]) >= (1 << (INS_W - 8))) begin exp_err = 1; return; end
          exp_q.push_back((k / 2 - 1) * (1 << INS_W) + int'(img_q[k]) * 256 + int'(lo));
        end
        s = s + img_q[k];
      end else begin
        if (img_q[k] == s) exp_done = 1;
        else exp_err = 2;
        return;
      end
    end
  endtask

  // corrupt: 0 clean, 1 bad high byte, 2 checksum+1, 3 one gap over limit, 4 one gap at limit
  task automatic build_image(input int n, input bit idx_data, input int gmax, input int corrupt);
    logic [7:0] s, lb, hb;
    logic [12:0] w;
    int bad;
    img_q.delete(); gap_q.delete();
    img_q.push_back(8'(n - 1) | (8'($urandom_range(0, 3)) << 6));
    s   = img_q[0];
    bad = $urandom_range(0, n - 1);
    for (int i = 0; i < n; i++) begin
      w  = idx_data ? 13'(i) : 13'($urandom_range(0, 8191));
      lb = w[7:0];
      hb = {3'b000, w[12:8]};
      if (corrupt == 1 && i == bad) hb = hb | (8'h20 << $urandom_range(0, 2));
      img_q.push_back(lb);
      img_q.push_back(hb);
      s = s + lb + hb;
    end
    img_q.push_back(corrupt == 2 ? s + 8'd1 : s);
    foreach (img_q[k]) gap_q.push_back($urandom_range(0, gmax));
    if (corrupt == 3) gap_q[$urandom_range(0, img_q.size() - 1)] = TIMEOUT + 1;
    if (corrupt == 4) gap_q[$urandom_range(0, img_q.size() - 1)] = TIMEOUT;
  endtask

  task automatic run_case(input string tag);
    bit ok;
    int acc, lim;
    model();
    act_q.delete();
    pulse_start();
    acc = 0;
    foreach (img_q[k]) begin
      send_byte(img_q[k], gap_q[k], ok);
      if (!ok) break;
      acc++;
    end
    tick();
    tick();
    check({tag, "_accepted"}, acc, exp_acc);
    check({tag, "_nwrites"}, act_q.size(), exp_q.size());
    lim = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++) check({tag, "_write"}, act_q[i], exp_q[i]);
    check({tag, "_err"}, int'(err_o), exp_err);
    check({tag, "_done"}, int'(done_o), exp_done);
    check({tag, "_core"}, int'(core_nreset_o), exp_done);
    check({tag, "_busy"}, int'(busy_o), 0);
  endtask

  initial begin
    bit ok;
    int c;

    // Reset state
    tick();
    tick();
    check("rst_core", int'(core_nreset_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_ready", int'(byte_ready_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_err", int'(err_o), 0);
    check("rst_we", int'(pm_we_o), 0);
    check("rst_addr", int'(pm_addr_o), 0);
    check("rst_data", int'(pm_data_o), 0);
    nReset = 1'b1;
    tick();
    check("idle_ready", int'(byte_ready_o), 0);

    // Directed single word, write latency and core release timing
    act_q.delete();
    pulse_start();
    check("t1_busy", int'(busy_o), 1);
    send_byte(8'h00, 0, ok);
    send_byte(8'h34, 0, ok);
    check("t1_no_we_lo", int'(pm_we_o), 0);
    send_byte(8'h12, 0, ok);
    check("t1_we", int'(pm_we_o), 1);
    check("t1_addr", int'(pm_addr_o), 0);
    check("t1_data", int'(pm_data_o), 'h1234);
    send_byte(8'h46, 0, ok);
    check("t1_we_pulse", int'(pm_we_o), 0);
    check("t1_done", int'(done_o), 1);
    check("t1_core_not_yet", int'(core_nreset_o), 0);
    tick();
    check("t1_core", int'(core_nreset_o), 1);
    check("t1_nwrites", act_q.size(), 1);
    check("t1_data_held", int'(pm_data_o), 'h1234);

    // Full 64-word image, data = index, gaps below the limit
    build_image(64, 1'b1, TIMEOUT - 1, 0);
    run_case("t2_full");
    check("t2_last_addr", int'(pm_addr_o), 63);

    // Bad high byte
    img_q = '{8'h00, 8'h34, 8'h32, 8'h66};
    gap_q = '{0, 0, 0, 0};
    run_case("t3_hibyte");
    check("t3_err", int'(err_o), 1);
    check("t3_ready", int'(byte_ready_o), 0);

    // Checksum off by one, then a clean retry
    img_q = '{8'h00, 8'hBC, 8'h0A, 8'hC7};
    gap_q = '{0, 0, 0, 0};
    run_case("t4_csum");
    check("t4_err", int'(err_o), 2);
    img_q[3] = 8'hC6;
    run_case("t4_retry");
    check("t4_err_clr", int'(err_o), 0);

    // Stall after LO: one cycle over the limit errors, exactly at the limit is accepted
    img_q = '{8'h00, 8'h34, 8'h12, 8'h46};
    gap_q = '{0, 0, TIMEOUT + 1, 0};
    run_case("t5_timeout");
    check("t5_err", int'(err_o), 3);
    gap_q = '{0, 0, TIMEOUT, 0};
    run_case("t5_edge");
    check("t5_edge_done", int'(done_o), 1);

    // Randomised images against the model
    for (int it = 0; it < 14; it++) begin
      c = $urandom_range(0, 5);
      build_image((it % 5 == 0) ? 64 : $urandom_range(1, 64), 1'b0, 3, (c > 4) ? 0 : c);
      run_case("rnd");
    end

    // Asynchronous reset mid-image
    pulse_start();
    send_byte(8'h01, 0, ok);
    send_byte(8'h11, 0, ok);
    send_byte(8'h05, 0, ok);
    #2 nReset = 1'b0;
    #1;
    check("t6_rst_busy", int'(busy_o), 0);
    check("t6_rst_we", int'(pm_we_o), 0);
    check("t6_rst_addr", int'(pm_addr_o), 0);
    check("t6_rst_err", int'(err_o), 0);
    check("t6_rst_core", int'(core_nreset_o), 0);
    tick();
    nReset = 1'b1;
    tick();
    check("t6_idle", int'(busy_o), 0);

    // start_i while busy is ignored
    act_q.delete();
    pulse_start();
    send_byte(8'h00, 0, ok);
    start_i = 1'b1;
    send_byte(8'h34, 0, ok);
    send_byte(8'h12, 0, ok);
    start_i = 1'b0;
    send_byte(8'h46, 0, ok);
    tick();
    check("t6_busy_start_done", int'(done_o), 1);
    check("t6_busy_start_writes", act_q.size(), 1);
    check("t6_core_up", int'(core_nreset_o), 1);

    // start_i in DONE drops the core reset on the next clock
    pulse_start();
    check("t6_core_fall", int'(core_nreset_o), 0);
    check("t6_restart_busy", int'(busy_o), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
